// File: rtl/alu_serial.sv
// Byte-serial ALU: executes one ALUControl op on two WIDTH-bit operands, CHUNK bits per
// cycle LSB first, with valid/ready handshakes on both the request and the result side.
module alu_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned NChunk = WIDTH / CHUNK;
  localparam int unsigned CntW   = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NChunk - 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSlt = 3'b101;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             last_chunk;
  logic             is_arith;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   sum;
  logic [CHUNK-1:0] chunk_res;
  logic             overflow;
  logic             less;
  logic [WIDTH-1:0] final_res;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (in_valid) state_d = StRun;
      StRun:  if (cnt_q == LastCnt) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    result    = result_q;
    zero      = zero_q;
  end

  assign accept     = (state_q == StIdle) && in_valid;
  assign last_chunk = (state_q == StRun) && (cnt_q == LastCnt);
  assign is_arith   = (op_q == OpAdd) || (op_q == OpSub) || (op_q == OpSlt);

  // One chunk of the datapath; sub/slt add the inverted operand with carry-in seeded to 1.
  always_comb begin
    a_chunk = a_q[cnt_q*CHUNK +: CHUNK];
    b_chunk = b_q[cnt_q*CHUNK +: CHUNK];
    b_eff   = (op_q == OpAdd) ? b_chunk : ~b_chunk;
    sum     = {1'b0, a_chunk} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_q};
    case (op_q)
      OpAdd, OpSub, OpSlt: chunk_res = sum[CHUNK-1:0];
      OpAnd:               chunk_res = a_chunk & b_chunk;
      OpOr:                chunk_res = a_chunk | b_chunk;
      OpXor:               chunk_res = a_chunk ^ b_chunk;
      default:             chunk_res = '0;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;

    if (accept) begin
      a_d     = a;
      b_d     = b;
      op_d    = ALUControl;
      cnt_d   = '0;
      carry_d = (ALUControl == OpSub) || (ALUControl == OpSlt);
      acc_d   = '0;
    end else if (state_q == StRun) begin
      acc_d[cnt_q*CHUNK +: CHUNK] = chunk_res;
      carry_d = is_arith ? sum[CHUNK] : carry_q;
      cnt_d   = cnt_q + CntW'(1);
    end

    // acc_d holds the complete difference on the last chunk, so its MSB is diff[MSB].
    overflow = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
    less     = acc_d[WIDTH-1] ^ overflow;
    case (op_q)
      OpAdd, OpSub, OpAnd, OpOr, OpXor: final_res = acc_d;
      OpSlt:                            final_res = {{(WIDTH-1){1'b0}}, less};
      default:                          final_res = '0;
    endcase

    if (last_chunk) begin
      result_d = final_res;
      zero_d   = (final_res == '0);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: directed cases plus randomized ops checked against
// a plain-arithmetic reference model.
module tb_alu_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alu_ctl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_serial #(
    .WIDTH(32),
    .CHUNK(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ALUControl(alu_ctl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      3'd5:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request in IDLE; returns just after the accepting edge.
  task automatic start(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top);
    @(negedge clk);
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    alu_ctl  = top;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    alu_ctl  = 3'($urandom);
  endtask

  // Follows an accepted request through RUN and DONE, stalling the consumer for stall cycles.
  task automatic finish_op(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                           input int stall);
    logic [31:0] exp;
    logic [4:0]  hist;
    exp  = ref_alu(ta, tb, top);
    hist = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      hist      = {hist[3:0], out_valid};
      out_ready = 1'($urandom);
      in_valid  = 1'($urandom);
      a         = $urandom;
      b         = $urandom;
      alu_ctl   = 3'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    hist     = {hist[3:0], out_valid};
    check("latency", {27'd0, hist}, 32'h0000_0001);
    check("result", result, exp);
    check("zero", {31'd0, zero}, {31'd0, (exp == 32'd0)});
    check("busy_ready", {31'd0, in_ready}, 32'd0);
    out_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_result", result, exp);
      check("hold_flags", {30'd0, out_valid, in_ready}, 32'd2);
      out_ready = (s == stall - 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("release", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                       input int stall);
    start(ta, tb, top);
    finish_op(ta, tb, top, stall);
  endtask

  initial begin
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] exp;
    logic [31:0] ra;
    logic [31:0] rb;
    reset     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    alu_ctl   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed cases
    do_op(32'h0000_00FF, 32'h0000_0001, 3'b000, 0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 1);
    do_op(32'h0000_0005, 32'h0000_0005, 3'b001, 0);
    do_op(32'hF0F0_F0F0, 32'hFFFF_0000, 3'b100, 0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 0);
    do_op(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 0);
    do_op(32'h7FFF_FFFF, 32'h8000_0000, 3'b101, 0);
    do_op(32'h0000_0003, 32'h0000_0003, 3'b101, 0);
    do_op(32'h0F0F_00FF, 32'h00FF_0F0F, 3'b010, 0);
    do_op(32'h0F0F_0000, 32'h0000_0F0F, 3'b011, 0);
    do_op(32'h1234_5678, 32'h0000_0000, 3'b110, 0);

    // Backpressure with a request queued behind the result
    start(32'h1234_5678, 32'h1111_1111, 3'b000);
    exp = 32'h2345_6789;
    repeat (5) @(negedge clk);
    check("bp_result", result, exp);
    qa        = 32'h0000_0010;
    qb        = 32'h0000_0020;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = qa;
    b         = qb;
    alu_ctl   = 3'b001;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("bp_hold_result", result, exp);
      check("bp_hold_flags", {30'd0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    finish_op(qa, qb, 3'b001, 0);

    // Reset during the second RUN cycle
    start(32'hAAAA_0000, 32'h0000_BBBB, 3'b011);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    do_op($urandom, $urandom, 3'b111, 0);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: ra = 32'h8000_0000 ^ 32'($urandom_range(0, 1));
        default: ;
      endcase
      do_op(ra, rb, 3'($urandom_range(0, 7)), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
